// File: rtl/tc_reload_pkg.sv
// Shared definitions for the timer/counter reload controller.
// Holds the controller state encoding and the default data width.
package tc_reload_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/tc_reload_ctrl.sv
// Reload controller for an external down counter: strobes a preset load, enables counting,
// reacts to terminal count in one-shot or periodic mode, and keeps IRQ/overrun/period status.
module tc_reload_ctrl
    import tc_reload_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic [WIDTH-1:0] PRESET,
    input  logic             TC,
    input  logic             IRQ_ACK,
    output logic             LD,
    output logic [WIDTH-1:0] LD_D,
    output logic             CNT_EN,
    output logic             BUSY,
    output logic             IRQ,
    output logic             OVR,
    output logic [WIDTH-1:0] PERIODS
);

    state_t state;
    state_t state_nxt;
    logic   mode_q;
    logic   start_ok;
    logic   tc_ok;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        tc_ok     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_nxt = ST_LOAD;
                    start_ok  = 1'b1;
                end
            end
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN: begin
                if (TC) begin
                    tc_ok     = 1'b1;
                    state_nxt = mode_q ? ST_LOAD : ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // STOP overrides everything: no capture, no TC bookkeeping.
        if (STOP) begin
            state_nxt = ST_IDLE;
            start_ok  = 1'b0;
            tc_ok     = 1'b0;
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= ST_IDLE;
            LD      <= 1'b0;
            LD_D    <= '0;
            CNT_EN  <= 1'b0;
            BUSY    <= 1'b0;
            IRQ     <= 1'b0;
            OVR     <= 1'b0;
            PERIODS <= '0;
            mode_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Strobes are decoded from the next state so they line up with the state itself.
            LD     <= (state_nxt == ST_LOAD);
            CNT_EN <= (state_nxt == ST_RUN);
            BUSY   <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);

            if (start_ok) begin
                LD_D    <= PRESET;
                mode_q  <= MODE;
                PERIODS <= '0;
            end else if (tc_ok && (PERIODS != '1)) begin
                PERIODS <= PERIODS + WIDTH'(1);
            end

            // A TC accepted in the same cycle as an acknowledge wins over the clear.
            if (tc_ok) begin
                IRQ <= 1'b1;
                if (IRQ && !IRQ_ACK) OVR <= 1'b1;
            end else if (IRQ_ACK) begin
                IRQ <= 1'b0;
                OVR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tc_reload_ctrl.sv
// Directed bench for tc_reload_ctrl; TC comes from a behavioural 8-bit down counter
// driven by the controller's LD/LD_D/CNT_EN, with an extra force input for stray TCs.
module tb_tc_reload_ctrl;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         START;
    logic         STOP;
    logic         MODE;
    logic [W-1:0] PRESET;
    logic         TC;
    logic         IRQ_ACK;
    logic         LD;
    logic [W-1:0] LD_D;
    logic         CNT_EN;
    logic         BUSY;
    logic         IRQ;
    logic         OVR;
    logic [W-1:0] PERIODS;

    logic [W-1:0] cnt = '0;
    logic         tc_force = 1'b0;

    int checks = 0;
    int errors = 0;

    tc_reload_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RSTN(RSTN), .START(START), .STOP(STOP), .MODE(MODE),
        .PRESET(PRESET), .TC(TC), .IRQ_ACK(IRQ_ACK), .LD(LD), .LD_D(LD_D),
        .CNT_EN(CNT_EN), .BUSY(BUSY), .IRQ(IRQ), .OVR(OVR), .PERIODS(PERIODS)
    );

    always #5 CLK = ~CLK;

    // Downstream down counter: synchronous load, count when enabled, carry-out at zero.
    always @(posedge CLK) begin
        if (LD) cnt <= LD_D;
        else if (CNT_EN) cnt <= cnt - 8'd1;
    end
    assign TC = tc_force | (CNT_EN && (cnt == 8'd0));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ld"},      32'(LD),      32'd0);
        check({tag, ".ld_d"},    32'(LD_D),    32'd0);
        check({tag, ".cnt_en"},  32'(CNT_EN),  32'd0);
        check({tag, ".busy"},    32'(BUSY),    32'd0);
        check({tag, ".irq"},     32'(IRQ),     32'd0);
        check({tag, ".ovr"},     32'(OVR),     32'd0);
        check({tag, ".periods"}, 32'(PERIODS), 32'd0);
    endtask

    initial begin
        RSTN = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 1'b0;
        PRESET = '0; IRQ_ACK = 1'b0;
        #1;
        check_reset_values("rst0");
        tick(3);
        check_reset_values("rst_held");
        #3 RSTN = 1'b1;
        tick(1);
        check("idle.busy", 32'(BUSY), 32'd0);

        // Periodic, preset 5: LD every 7 cycles, PERIODS 1,2,3, OVR after second TC.
        PRESET = 8'd5; MODE = 1'b1; START = 1'b1;
        tick(1);
        START = 1'b0;
        check("p5.t0.ld",   32'(LD),     32'd1);
        check("p5.t0.ldd",  32'(LD_D),   32'd5);
        check("p5.t0.busy", 32'(BUSY),   32'd1);
        check("p5.t0.en",   32'(CNT_EN), 32'd0);
        for (int k = 1; k <= 21; k++) begin
            tick(1);
            check($sformatf("p5.t%0d.ld", k),      32'(LD),      32'(k % 7 == 0));
            check($sformatf("p5.t%0d.en", k),      32'(CNT_EN),  32'(k % 7 != 0));
            check($sformatf("p5.t%0d.periods", k), 32'(PERIODS), 32'(k / 7));
            check($sformatf("p5.t%0d.irq", k),     32'(IRQ),     32'(k >= 7));
            check($sformatf("p5.t%0d.ovr", k),     32'(OVR),     32'(k >= 14));
        end
        IRQ_ACK = 1'b1;
        tick(1);                                   // t=22, state RUN, no TC
        IRQ_ACK = 1'b0;
        check("ack.irq", 32'(IRQ), 32'd0);
        check("ack.ovr", 32'(OVR), 32'd0);
        tick(6);                                   // t=28, fourth TC accepted
        check("p5.t28.irq",     32'(IRQ),     32'd1);
        check("p5.t28.ovr",     32'(OVR),     32'd0);
        check("p5.t28.periods", 32'(PERIODS), 32'd4);
        tick(6);                                   // t=34, TC pending
        IRQ_ACK = 1'b1;
        tick(1);                                   // t=35, ack coincident with TC
        check("ackTC.irq",     32'(IRQ),     32'd1);
        check("ackTC.ovr",     32'(OVR),     32'd0);
        check("ackTC.periods", 32'(PERIODS), 32'd5);
        check("ackTC.ld",      32'(LD),      32'd1);
        tick(1);                                   // t=36, plain ack clears
        IRQ_ACK = 1'b0;
        check("ack2.irq", 32'(IRQ), 32'd0);

        // STOP coincident with TC at t=42.
        tick(5);                                   // t=41
        check("stop.tc_present", 32'(TC), 32'd1);
        STOP = 1'b1;
        tick(1);
        STOP = 1'b0;
        check("stop.busy",    32'(BUSY),    32'd0);
        check("stop.en",      32'(CNT_EN),  32'd0);
        check("stop.ld",      32'(LD),      32'd0);
        check("stop.irq",     32'(IRQ),     32'd0);
        check("stop.periods", 32'(PERIODS), 32'd5);
        tick(2);
        check("stop.hold", 32'(BUSY), 32'd0);

        // One-shot, preset 3: one LD, CNT_EN for 4 cycles, then DONE.
        PRESET = 8'd3; MODE = 1'b0; START = 1'b1;
        tick(1);
        START = 1'b0;
        check("os.ld",      32'(LD),      32'd1);
        check("os.ldd",     32'(LD_D),    32'd3);
        check("os.periods", 32'(PERIODS), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            check($sformatf("os.t%0d.en", k), 32'(CNT_EN), 32'd1);
            check($sformatf("os.t%0d.ld", k), 32'(LD),     32'd0);
        end
        tick(1);
        check("os.done.en",      32'(CNT_EN),  32'd0);
        check("os.done.busy",    32'(BUSY),    32'd0);
        check("os.done.irq",     32'(IRQ),     32'd1);
        check("os.done.periods", 32'(PERIODS), 32'd1);
        tick(1);
        check("os.done.ld", 32'(LD), 32'd0);
        tc_force = 1'b1;                           // stray TC in DONE must be ignored
        tick(1);
        tc_force = 1'b0;
        check("os.tcign.periods", 32'(PERIODS), 32'd1);
        check("os.tcign.ovr",     32'(OVR),     32'd0);
        check("os.tcign.busy",    32'(BUSY),    32'd0);

        // Asynchronous reset mid-RUN, restarted directly from DONE.
        PRESET = 8'd10; MODE = 1'b1; START = 1'b1;
        tick(1);
        START = 1'b0;
        check("ar.load.periods", 32'(PERIODS), 32'd0);
        tick(1);
        check("ar.run.en", 32'(CNT_EN), 32'd1);
        #2 RSTN = 1'b0;
        #1;
        check_reset_values("ar.async");
        tick(1);
        check_reset_values("ar.held");
        #3 RSTN = 1'b1;
        tick(1);
        check("ar.idle.busy", 32'(BUSY), 32'd0);

        // Preset 0 periodic: LD every 2 cycles, PERIODS saturates at 255.
        PRESET = 8'd0; MODE = 1'b1; START = 1'b1;
        tick(1);
        START = 1'b0;
        check("p0.t0.ld", 32'(LD), 32'd1);
        for (int k = 1; k <= 600; k++) begin
            tick(1);
            check($sformatf("p0.t%0d.ld", k),      32'(LD),      32'(k % 2 == 0));
            check($sformatf("p0.t%0d.periods", k), 32'(PERIODS), 32'((k / 2 > 255) ? 255 : k / 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_reload_ctrl.md
TC_RELOAD_CTRL -- requirements
Module: tc_reload_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the preset value, the load data and the period counter.
REQ-002 SHALL have port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port RSTN, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port START, input, 1: begin timing; sampled in IDLE and DONE only.
REQ-005 SHALL have port STOP, input, 1: abort timing; return to IDLE.
REQ-006 SHALL have port MODE, input, 1: 0 = one-shot, 1 = periodic; captured on START.
REQ-007 SHALL have port PRESET, input, WIDTH: reload value; captured on START.
REQ-008 SHALL have port TC, input, 1: terminal count from the downstream down counter's carry-out (CAO).
REQ-009 SHALL have port IRQ_ACK, input, 1: clears IRQ and OVR.
REQ-010 SHALL have port LD, output, 1: load strobe to the counter.
REQ-011 SHALL have port LD_D, output, WIDTH: load data to the counter; equals the captured preset.
REQ-012 SHALL have port CNT_EN, output, 1: count enable to the counter's EN and CAI.
REQ-013 SHALL have port BUSY, output, 1: high in LOAD and RUN.
REQ-014 SHALL have port IRQ, output, 1: sticky terminal-count flag.
REQ-015 SHALL have port OVR, output, 1: sticky overrun flag; TC occurred while IRQ was still pending.
REQ-016 SHALL have port PERIODS, output, WIDTH: count of completed periods; saturates at all-ones.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RUN and DONE.
REQ-018 SHALL move from IDLE or DONE to LOAD on START=1 and STOP=0, capturing PRESET and MODE and clearing PERIODS on that edge.
REQ-019 SHALL spend exactly one cycle in LOAD, with LD=1 and CNT_EN=0, then move to RUN.
REQ-020 SHALL drive CNT_EN=1 and LD=0 in RUN.
REQ-021 SHALL, on TC=1 in RUN, move to LOAD when the captured mode is periodic, or to DONE when it is one-shot.
REQ-022 SHALL produce a periodic-mode period of exactly captured preset + 2 cycles: preset+1 RUN cycles plus 1 LOAD cycle.
REQ-023 SHALL drive LD=0 and CNT_EN=0 in IDLE and DONE.
REQ-024 SHALL ignore TC outside RUN.
REQ-025 SHALL ignore START while in LOAD or RUN.
REQ-026 SHALL give STOP priority over START and TC in every state: next state IDLE, no IRQ set, no PERIODS increment.
REQ-027 SHALL, on each TC accepted in RUN, set IRQ=1 and increment PERIODS; at all-ones, PERIODS holds.
REQ-028 SHALL, on TC accepted in RUN while IRQ=1 and IRQ_ACK=0, set OVR=1.
REQ-029 SHALL, on IRQ_ACK=1, clear IRQ and OVR on the next edge, except that a same-cycle accepted TC leaves IRQ=1 and OVR unchanged (set wins over clear).
REQ-030 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-031 SHALL be correct for a preset of 0: period 2 cycles, TC on the first RUN cycle.

Reset
REQ-032 SHALL, while RSTN=0, force state IDLE and LD=0, LD_D=0, CNT_EN=0, BUSY=0, IRQ=0, OVR=0, PERIODS=0, and clear the captured preset and mode.
REQ-033 SHALL, on reset asserted mid-operation (LOAD or RUN), drop CNT_EN and LD immediately, without waiting for CLK.
REQ-034 SHALL take the first possible transition on the first CLK edge after RSTN rises.

Structure
REQ-035 SHALL take the state enumeration and the default WIDTH constant from the shared package tc_reload_pkg.
REQ-036 SHALL be a single module with no sub-modules; the saturating PERIODS counter is inline.

Verification
REQ-037 SHALL cover: PRESET=5, MODE=1, START pulse, TC modelled from an 8-bit down counter -> LD every 7 cycles, PERIODS increments 1, 2, 3, IRQ high after the first TC.
REQ-038 SHALL cover: PRESET=3, MODE=0 -> one LD, CNT_EN high for 4 cycles, then DONE, BUSY=0, IRQ=1, PERIODS=1.
REQ-039 SHALL cover: periodic mode with no IRQ_ACK across two TCs -> OVR=1 after the second TC; IRQ_ACK -> IRQ=0 and OVR=0 next cycle; IRQ_ACK coincident with TC -> IRQ stays 1.
REQ-040 SHALL cover: STOP asserted in the same cycle as TC -> IDLE, IRQ stays 0, PERIODS unchanged.
REQ-041 SHALL cover: RSTN driven low asynchronously mid-RUN -> CNT_EN=0 before the next CLK edge; all outputs at their reset values.
REQ-042 SHALL cover: PRESET=0, MODE=1 -> LD every 2 cycles; PERIODS saturates at 255 after 255+ periods.
